// File: rtl/imem_pkg.sv
// Shared state encoding, NOP instruction word and default sizing for the
// instruction-memory responder and its storage array.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSN        = 32'h0000_0013;
  localparam int          DEFAULT_LATENCY = 2;
  localparam int          DEFAULT_DEPTH   = 1024;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage: one write port, one registered read port
// (read-first on same-word collision, one edge of latency, never stalls).
module imem_array
  import imem_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [BITS-1:0]          wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [BITS-1:0]          rd_data
);

  logic [BITS-1:0] mem [DEPTH];

  // Contents survive reset so a preloaded image outlives a core restart.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Sampling before the write lands gives old data on a same-edge collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: one request in flight, response LATENCY edges after accept;
// mem_rdy drops only while waiting, so a request can be taken in the response cycle.
module imem_responder
  import imem_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req,
  input  logic [BITS-1:0]          addr,
  output logic                     mem_rdy,
  output logic                     valid,
  output logic [BITS-1:0]          rdata,
  output logic                     err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [BITS-1:0]          load_data
);

  localparam int AW = $clog2(DEPTH);

  state_t          state;
  logic [3:0]      cnt;
  logic            err_pend;
  logic            oor_q;
  logic [BITS-1:0] arr_q;
  logic [BITS-1:0] word_idx;
  logic            req_oor;
  logic            req_err;
  logic            accept;

  // Ready is low throughout reset and comes up in the first cycle after release.
  assign mem_rdy  = rst && (state != WAIT);
  assign accept   = proc_req && mem_rdy;
  assign word_idx = addr >> 2;
  assign req_oor  = (word_idx >= BITS'(DEPTH));
  assign req_err  = req_oor || (addr[1:0] != 2'b00);

  imem_array #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (accept),
    .rd_addr (addr[AW+1:2]),
    .rd_data (arr_q)
  );

  // Out-of-range fetches return a NOP instead of whatever the array aliased to.
  assign rdata = oor_q ? BITS'(NOP_INSN) : arr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            oor_q <= req_oor;
            if (LATENCY == 1) begin
              state <= RESP;
              valid <= 1'b1;
              err   <= req_err;
            end else begin
              state    <= WAIT;
              cnt      <= 4'(LATENCY - 2);
              err_pend <= req_err;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            valid <= 1'b1;
            err   <= err_pend;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances at LATENCY 1, 2 and 4 sharing the
// clock, reset and preload port; responses are matched against a scoreboard.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int ND    = 3;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] proc_req_v;
  logic [ND-1:0] mem_rdy_v;
  logic [ND-1:0] valid_v;
  logic [ND-1:0] err_v;
  logic [31:0]   addr_v  [ND];
  logic [31:0]   rdata_v [ND];
  logic          load_en;
  logic [5:0]    load_addr;
  logic [31:0]   load_data;

  logic [31:0] mdl [DEPTH];
  exp_t        sb[$];
  vec_t        tbl [8];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          vcount [ND] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    imem_responder #(
      .BITS    (32),
      .DEPTH   (DEPTH),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .proc_req  (proc_req_v[g]),
      .addr      (addr_v[g]),
      .mem_rdy   (mem_rdy_v[g]),
      .valid     (valid_v[g]),
      .rdata     (rdata_v[g]),
      .err       (err_v[g]),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic logic exp_oor(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (exp_oor(a)) return NOP_INSN;
    return mdl[a[7:2]];
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return exp_oor(a) || (a[1:0] != 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] er, input logic ee);
    exp_t e;
    e.dut   = d;
    e.cyc   = cyc + lat_of(d);
    e.rdata = er;
    e.err   = ee;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic req_go(input int d, input logic [31:0] a, input logic [31:0] er, input logic ee);
    chk("rdy_before_req", 32'(mem_rdy_v[d]), 32'd1);
    proc_req_v[d] = 1'b1;
    addr_v[d]     = a;
    push_exp(d, er, ee);
    @(negedge clk);
    proc_req_v[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (valid_v[d] === 1'b1) begin
        vcount[d]++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: dut %0d valid=1 rdata %h, expected no response", d, rdata_v[d]);
        end else begin
          e = sb.pop_front();
          chk("resp_dut", 32'(d), 32'(e.dut));
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk("resp_rdata", rdata_v[d], e.rdata);
          chk("resp_err", 32'(err_v[d]), 32'(e.err));
        end
      end else begin
        chk("err_without_valid", 32'(err_v[d]), 32'd0);
      end
    end
  end

  initial begin
    int v0;
    tbl[0] = '{32'h0000_000C, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{32'h0000_0006, pat(1),        1'b1};
    tbl[2] = '{32'(DEPTH * 4), NOP_INSN,     1'b1};
    tbl[3] = '{32'h0000_0000, pat(0),        1'b0};
    tbl[4] = '{32'h0000_00FC, pat(63),       1'b0};
    tbl[5] = '{32'h0000_00FF, pat(63),       1'b1};
    tbl[6] = '{32'h0000_000F, 32'hDEAD_BEEF, 1'b1};
    tbl[7] = '{32'hFFFF_FFFC, NOP_INSN,      1'b1};

    rst        = 1'b0;
    proc_req_v = '0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    for (int d = 0; d < ND; d++) addr_v[d] = '0;

    #2;
    for (int d = 0; d < ND; d++) begin
      chk("reset_rdy", 32'(mem_rdy_v[d]), 32'd0);
      chk("reset_valid", 32'(valid_v[d]), 32'd0);
      chk("reset_rdata", rdata_v[d], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) chk("rdy_on_release", 32'(mem_rdy_v[d]), 32'd1);
    @(negedge clk);

    for (int w = 0; w < DEPTH; w++) begin
      load_en   = 1'b1;
      load_addr = 6'(w);
      load_data = (w == 3) ? 32'hDEAD_BEEF : ((w == 5) ? 32'h1111_1111 : pat(w));
      mdl[w]    = load_data;
      @(negedge clk);
    end
    load_en = 1'b0;

    // Single requests at LATENCY=2: one cycle of backpressure, then the response.
    for (int i = 0; i < 8; i++) begin
      req_go(1, tbl[i].addr, tbl[i].rdata, tbl[i].err);
      chk("l2_wait_rdy", 32'(mem_rdy_v[1]), 32'd0);
      @(negedge clk);
      chk("l2_resp_rdy", 32'(mem_rdy_v[1]), 32'd1);
      chk("l2_resp_valid", 32'(valid_v[1]), 32'd1);
      drain();
    end

    // Back-to-back at LATENCY=1 with proc_req held high.
    for (int k = 0; k < 3; k++) begin
      if (k > 0) chk("b2b_rdy", 32'(mem_rdy_v[0]), 32'd1);
      proc_req_v[0] = 1'b1;
      addr_v[0]     = 32'(k * 4);
      push_exp(0, exp_rd(32'(k * 4)), 1'b0);
      @(negedge clk);
    end
    proc_req_v[0] = 1'b0;
    drain();

    // Load and fetch of the same word on one edge returns the old word.
    load_en   = 1'b1;
    load_addr = 6'd5;
    load_data = 32'h2222_2222;
    req_go(1, 32'h0000_0014, 32'h1111_1111, 1'b0);
    load_en = 1'b0;
    mdl[5]  = 32'h2222_2222;
    drain();
    req_go(1, 32'h0000_0014, 32'h2222_2222, 1'b0);
    drain();

    // Requests while waiting at LATENCY=4 must not disturb the captured address.
    v0 = vcount[2];
    req_go(2, 32'h0000_0008, exp_rd(32'h8), exp_err(32'h8));
    chk("ign_rdy_a", 32'(mem_rdy_v[2]), 32'd0);
    proc_req_v[2] = 1'b1;
    addr_v[2]     = 32'h0000_0020;
    @(negedge clk);
    chk("ign_rdy_b", 32'(mem_rdy_v[2]), 32'd0);
    proc_req_v[2] = 1'b0;
    @(negedge clk);
    chk("ign_rdy_c", 32'(mem_rdy_v[2]), 32'd0);
    proc_req_v[2] = 1'b1;
    addr_v[2]     = 32'h0000_0024;
    @(negedge clk);
    proc_req_v[2] = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("ign_single_resp", 32'(vcount[2] - v0), 32'd1);

    // Reset in the middle of a LATENCY=4 wait drops the request silently.
    chk("rst_rdy_idle", 32'(mem_rdy_v[2]), 32'd1);
    proc_req_v[2] = 1'b1;
    addr_v[2]     = 32'h0000_0010;
    @(negedge clk);
    proc_req_v[2] = 1'b0;
    chk("rst_in_wait", 32'(mem_rdy_v[2]), 32'd0);
    v0  = vcount[2];
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_v[2]), 32'd0);
    chk("rst_err", 32'(err_v[2]), 32'd0);
    chk("rst_rdata", rdata_v[2], 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rdy_held", 32'(mem_rdy_v[2]), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("rst_rdy_release", 32'(mem_rdy_v[2]), 32'd1);
    repeat (8) @(negedge clk);
    chk("rst_no_valid", 32'(vcount[2] - v0), 32'd0);

    // Storage survives reset.
    req_go(2, 32'h0000_0014, 32'h2222_2222, 1'b0);
    drain();

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of BITS-wide words in storage.
REQ-003 SHALL have parameter LATENCY, default 2, meaning edges from request acceptance to response (legal 1..15).
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port proc_req  input  1  fetch request from the initiator.
REQ-007 SHALL have port addr  input  BITS  byte address, sampled with the request.
REQ-008 SHALL have port mem_rdy  output  1  responder can accept a request this cycle.
REQ-009 SHALL have port valid  output  1  rdata holds the response this cycle.
REQ-010 SHALL have port rdata  output  BITS  instruction word.
REQ-011 SHALL have port err  output  1  response is for a misaligned or out-of-range address.
REQ-012 SHALL have ports load_en  input  1, load_addr  input  $clog2(DEPTH), and load_data  input  BITS, forming the word-indexed preload write port.

Function
REQ-013 SHALL accept a request at a rising edge where proc_req=1 and mem_rdy=1, capturing addr internally.
REQ-014 SHALL implement states IDLE, WAIT, RESP; mem_rdy=1 in IDLE and RESP, 0 in WAIT.
REQ-015 SHALL transition on acceptance to RESP if LATENCY=1, else to WAIT with counter loaded to LATENCY-2.
REQ-016 SHALL decrement the WAIT counter each edge and go to RESP when it is 0.
REQ-017 SHALL drive valid=1 for exactly one cycle in RESP, beginning LATENCY edges after the accepting edge.
REQ-018 SHALL, on a new request accepted in RESP (back-to-back), restart per REQ-015; otherwise return to IDLE.
REQ-019 SHALL read storage word addr[$clog2(DEPTH)+1:2] at the accepting edge into a response register; rdata is only meaningful when valid=1 and holds its last value otherwise.
REQ-020 SHALL, when addr[1:0]!=0, respond with the aligned word and err=1.
REQ-021 SHALL, when addr/4 >= DEPTH, respond with rdata=32'h00000013 (NOP) and err=1.
REQ-022 SHALL hold err=0 whenever valid=0.
REQ-023 SHALL write load_data to load_addr at any rising edge where load_en=1, independent of state.
REQ-024 SHALL return the pre-write data when a load and an accepted request target the same word at the same edge.
REQ-025 SHALL ignore proc_req whenever mem_rdy=0; the captured address is not overwritten in WAIT.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, counter=0, valid=0, err=0, rdata=0, mem_rdy=0.
REQ-027 SHALL assert mem_rdy=1 from the first cycle with rst=1 (state IDLE).
REQ-028 SHALL abort any in-flight request on reset without emitting valid; storage contents are not reset.

Structure
REQ-029 SHALL place the state enum type, NOP constant 32'h00000013, and default LATENCY/DEPTH constants in shared package imem_pkg.
REQ-030 SHALL instantiate one sub-module, imem_array (single write port plus one synchronous read port), for storage; the FSM and response register stay in imem_responder.

Verification
REQ-031 SHALL verify the basic read: preload word 3=32'hDEADBEEF, LATENCY=2, request addr=0x0C -> mem_rdy low 1 cycle, valid=1 two edges after acceptance, rdata=DEADBEEF, err=0.
REQ-032 SHALL verify back-to-back: LATENCY=1, proc_req held high with addr 0x0,0x4,0x8 on successive accepts -> valid high three consecutive cycles, with correct words in order.
REQ-033 SHALL verify error handling: request addr=0x06 -> aligned word 1 returned with err=1; request addr=DEPTH*4 -> rdata=0x00000013, err=1.
REQ-034 SHALL verify the load/read collision: word 5=0x11111111, same-edge load 0x22222222 to word 5 and request 0x14 -> rdata=0x11111111; next request -> 0x22222222.
REQ-035 SHALL verify mid-operation reset: rst low during WAIT (LATENCY=4) -> no valid pulse, mem_rdy=0 during reset, mem_rdy=1 first cycle after release.
REQ-036 SHALL verify the ignore rule: proc_req toggling with new addr while in WAIT -> response uses the originally accepted address.
